mult_accumulator: RTL and testbench



---
 rtl/mult_accumulator_pkg.sv | 16 +
 rtl/mult_accumulator_acc_adder.sv | 38 +++
 rtl/mult_accumulator.sv | 134 +++++++++++++
 tb/tb_mult_accumulator.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_accumulator_pkg.sv
// Shared types and constants for the MAC back-end accumulator.
// Used by mult_accumulator and its acc_adder sub-module.
package mult_accumulator_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 10;
  localparam int CNT_W      = 8;

  localparam logic [ACC_W_DEF-1:0] ACC_MAX = {ACC_W_DEF{1'b1}};

endpackage

// File: rtl/mult_accumulator_acc_adder.sv
// Combinational accumulator adder: acc + zero-extended product.
// ACC_SAT_EN selects saturation at all-ones (with sat flag); otherwise wraps.
module acc_adder
  import mult_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_prod,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_sat
);

`ifdef ACC_SAT_EN
  localparam int SUM_W = ACC_W + 1;
  logic [SUM_W-1:0] w_full;

  // Widen by one bit so the carry-out marks saturation.
  always_comb begin
    w_full = SUM_W'(i_acc) + SUM_W'(i_prod);
    if (w_full[ACC_W]) begin
      o_sum = {ACC_W{1'b1}};
      o_sat = 1'b1;
    end else begin
      o_sum = w_full[ACC_W-1:0];
      o_sat = 1'b0;
    end
  end
`else
  // Plain modulo-2^ACC_W sum; sat flag never raised.
  always_comb begin
    o_sum = i_acc + ACC_W'(i_prod);
    o_sat = 1'b0;
  end
`endif

endmodule

// File: rtl/mult_accumulator.sv
// Sums blocks of COUNT products from valid/ready input, holds each sum on valid/ready output.
// Optional ACC_SAT_EN (see acc_adder) saturates the sum and drives ovf.
module mult_accumulator
  import mult_accumulator_pkg::*;
#(
  parameter int COUNT  = 4,
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              ovf
);

  state_e             r_state;
  state_e             w_next;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sat;
  logic [ACC_W-1:0]   r_out_data;
  logic               r_ovf;
  logic [ACC_W-1:0]   w_sum;
  logic               w_sat;
  logic               w_xfer;
  logic               w_last;

  acc_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_acc_adder (
    .i_acc  (r_acc),
    .i_prod (in_data),
    .o_sum  (w_sum),
    .o_sat  (w_sat)
  );

  assign w_xfer = in_valid && in_ready;
  assign w_last = (r_cnt == CNT_W'(COUNT - 1));

  // State register: reset and clear both force ACCUM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCUM;
    end else if (clear) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ACCUM: begin
        if (w_xfer && w_last) begin
          w_next = DONE;
        end else begin
          w_next = ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_next = ACCUM;
        end else begin
          w_next = DONE;
        end
      end
      default: w_next = ACCUM;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ACCUM: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Accumulator, product counter and result buffer; r_sat tracks saturation within the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_sat      <= 1'b0;
      r_out_data <= '0;
      r_ovf      <= 1'b0;
    end else if (clear) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_xfer) begin
      if (w_last) begin
        r_out_data <= w_sum;
        r_ovf      <= r_sat | w_sat;
        r_acc      <= '0;
        r_cnt      <= '0;
        r_sat      <= 1'b0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CNT_W'(1);
        r_sat <= r_sat | w_sat;
      end
    end else begin
      r_acc <= r_acc;
      r_cnt <= r_cnt;
    end
  end

  assign out_data = r_out_data;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed bench for mult_accumulator: default block, ACC_W=8/COUNT=2 overflow block, COUNT=1 block.
// Expected overflow results follow ACC_SAT_EN when it is defined for the build.
module tb_mult_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf;
  logic [7:0] a_in_data;
  logic [9:0] a_out_data;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf;
  logic [7:0] b_in_data;
  logic [7:0] b_out_data;

  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_ovf;
  logic [7:0] c_in_data;
  logic [9:0] c_out_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_accumulator #(.COUNT(4), .PROD_W(8), .ACC_W(10)) u_dut_a (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .ovf(a_ovf)
  );

  mult_accumulator #(.COUNT(2), .PROD_W(8), .ACC_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .ovf(b_ovf)
  );

  mult_accumulator #(.COUNT(1), .PROD_W(8), .ACC_W(10)) u_dut_c (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready),
    .out_valid(c_out_valid), .out_data(c_out_data), .out_ready(c_out_ready),
    .ovf(c_ovf)
  );

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One transfer into instance A; inputs change on the falling edge only.
  task automatic feed_a(input logic [7:0] d);
    a_in_valid = 1'b1;
    a_in_data  = d;
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0;
    a_in_valid = 1'b0; a_in_data = 8'd0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = 8'd0; b_out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_data = 8'd0; c_out_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk_vec("rst_out_valid", a_out_valid, 1'b0);
    chk_vec("rst_out_data",  a_out_data, 10'd0);
    chk_vec("rst_ovf",       a_ovf, 1'b0);
    chk_vec("rst_in_ready",  a_in_ready, 1'b1);
    rst = 1'b0;

    // 225 x 4 with consumer always ready
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = 8'd225;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) begin
        chk_vec("t1_in_ready",  a_in_ready, 1'b1);
        chk_vec("t1_out_valid", a_out_valid, 1'b0);
      end
    end
    chk_vec("t1_done_valid", a_out_valid, 1'b1);
    chk_vec("t1_done_data",  a_out_data, 10'd900);
    chk_vec("t1_done_ovf",   a_ovf, 1'b0);
    chk_vec("t1_done_ready", a_in_ready, 1'b0);
    a_in_valid = 1'b0;
    @(negedge clk);
    chk_vec("t1_back_valid", a_out_valid, 1'b0);
    chk_vec("t1_back_ready", a_in_ready, 1'b1);

    // 1,2,3,4 with 2-cycle gaps, consumer stalled
    a_out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      feed_a(8'(i));
      if (i < 4) begin
        repeat (2) begin
          @(negedge clk);
          chk_vec("t2_gap_valid", a_out_valid, 1'b0);
          chk_vec("t2_gap_ready", a_in_ready, 1'b1);
        end
      end
    end
    a_in_valid = 1'b1;
    a_in_data  = 8'd50;
    repeat (5) begin
      @(negedge clk);
      chk_vec("t2_hold_valid", a_out_valid, 1'b1);
      chk_vec("t2_hold_data",  a_out_data, 10'd10);
      chk_vec("t2_hold_ready", a_in_ready, 1'b0);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    chk_vec("t2_release", a_out_valid, 1'b0);
    for (int i = 0; i < 4; i++) feed_a(8'd1);
    chk_vec("t2_nocount_valid", a_out_valid, 1'b1);
    chk_vec("t2_nocount_data",  a_out_data, 10'd4);
    @(negedge clk);

    // 7,8 then clear then 1,2,3,4
    a_out_ready = 1'b0;
    feed_a(8'd7);
    feed_a(8'd8);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk_vec("t3_clr_valid", a_out_valid, 1'b0);
    chk_vec("t3_clr_ready", a_in_ready, 1'b1);
    feed_a(8'd1);
    feed_a(8'd2);
    feed_a(8'd3);
    chk_vec("t3_mid_valid", a_out_valid, 1'b0);
    feed_a(8'd4);
    chk_vec("t3_valid", a_out_valid, 1'b1);
    chk_vec("t3_data",  a_out_data, 10'd10);
    a_out_ready = 1'b1;
    @(negedge clk);
    chk_vec("t3_back", a_out_valid, 1'b0);

    // reset while a result waits unconsumed
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) feed_a(8'd9);
    chk_vec("t5_pre_data", a_out_data, 10'd36);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_vec("t5_rst_valid", a_out_valid, 1'b0);
    chk_vec("t5_rst_data",  a_out_data, 10'd0);
    chk_vec("t5_rst_ready", a_in_ready, 1'b1);
    for (int i = 0; i < 4; i++) feed_a(8'd5);
    chk_vec("t5_valid", a_out_valid, 1'b1);
    chk_vec("t5_data",  a_out_data, 10'd20);
    a_out_ready = 1'b1;
    @(negedge clk);

    // ACC_W=8, COUNT=2: 200 + 100 overflows
    b_in_valid = 1'b1;
    b_in_data  = 8'd200;
    @(negedge clk);
    b_in_data  = 8'd100;
    @(negedge clk);
    b_in_valid = 1'b0;
    chk_vec("t4_valid", b_out_valid, 1'b1);
`ifdef ACC_SAT_EN
    chk_vec("t4_data", b_out_data, 8'd255);
    chk_vec("t4_ovf",  b_ovf, 1'b1);
`else
    chk_vec("t4_data", b_out_data, 8'd44);
    chk_vec("t4_ovf",  b_ovf, 1'b0);
`endif
    b_out_ready = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b1;
    b_in_data  = 8'd10;
    @(negedge clk);
    b_in_data  = 8'd20;
    @(negedge clk);
    b_in_valid = 1'b0;
    chk_vec("t4_next_data", b_out_data, 8'd30);
    chk_vec("t4_next_ovf",  b_ovf, 1'b0);

    // COUNT=1: 9 then 81 back-to-back
    c_out_ready = 1'b1;
    c_in_valid  = 1'b1;
    c_in_data   = 8'd9;
    @(negedge clk);
    chk_vec("t6_a_valid", c_out_valid, 1'b1);
    chk_vec("t6_a_data",  c_out_data, 10'd9);
    chk_vec("t6_a_ready", c_in_ready, 1'b0);
    c_in_data = 8'd81;
    @(negedge clk);
    chk_vec("t6_gap_ready", c_in_ready, 1'b1);
    chk_vec("t6_gap_valid", c_out_valid, 1'b0);
    @(negedge clk);
    chk_vec("t6_b_valid", c_out_valid, 1'b1);
    chk_vec("t6_b_data",  c_out_data, 10'd81);
    chk_vec("t6_b_ready", c_in_ready, 1'b0);
    c_in_valid = 1'b0;
    @(negedge clk);
    chk_vec("t6_end_ready", c_in_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
